tfhe_axi_burst_writer: RTL and testbench

AXI4 write-channel engine downstream of the PBS accelerator core. It drains the 256-bit result stream produced by the PBS pipeline and writes it to host memory as INCR bursts. Bursts start at host_wr_addr and cover host_wr_len bytes. It drives the AW/W/B channels of the M00 AXI master port and reports busy, done and error to the control slave.

---
 rtl/tfhe_axi_pkg.sv | 25 ++
 rtl/tfhe_wr_burst_calc.sv | 25 ++
 rtl/tfhe_axi_burst_writer.sv | 187 ++++++++++++++++++
 tb/tb_tfhe_axi_burst_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tfhe_axi_pkg.sv
// Shared AXI constants and write-engine state encoding for the PBS result writer.
package tfhe_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } wr_state_t;

    // AXI AxSIZE encoding for a power-of-two beat width in bytes.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        logic [2:0] s;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/tfhe_wr_burst_calc.sv
// Combinational AW address/length generator for one INCR burst of the result writer.
module tfhe_wr_burst_calc #(
    parameter logic [63:0] BASE_ADDR    = 64'h40000000,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned S_DATA_WIDTH = 32
) (
    input  logic [S_DATA_WIDTH-1:0] host_addr,
    input  logic [31:0]             remaining,
    input  logic [31:0]             burst_idx,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen
);

    localparam int unsigned BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int unsigned BURST_SHIFT = $clog2(BURST_BYTES);

    always_comb begin
        awaddr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(host_addr)
               + (ADDR_WIDTH'(burst_idx) << BURST_SHIFT);
        awlen  = (remaining >= 32'(BURST_LEN)) ? 8'(BURST_LEN - 1) : 8'(remaining - 32'd1);
    end

endmodule

// File: rtl/tfhe_axi_burst_writer.sv
// AXI4 write engine draining the PBS result stream into host memory as INCR bursts.
// Optional TFHE_WR_PERF_CNT_EN adds the wr_stall_cycles data-phase stall counter.
module tfhe_axi_burst_writer
    import tfhe_axi_pkg::*;
#(
    parameter logic [63:0] C_M_TARGET_SLAVE_BASE_ADDR = 64'h40000000,
    parameter int unsigned C_M_AXI_BURST_LEN          = 16,
    parameter int unsigned C_M_AXI_ADDR_WIDTH         = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH         = 256,
    parameter int unsigned C_S_AXI_DATA_WIDTH         = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          start_wr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] host_wr_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] host_wr_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_res_data,
    input  logic                          s_res_valid,
    output logic                          s_res_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic                          wr_busy,
    output logic                          wr_done,
    output logic                          wr_error
`ifdef TFHE_WR_PERF_CNT_EN
    ,
    output logic [31:0]                   wr_stall_cycles
`endif
);

    localparam int unsigned BEAT_SHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);

    wr_state_t                         state;
    logic [C_S_AXI_DATA_WIDTH-1:0]     host_addr_q;
    logic [31:0]                       remaining;
    logic [31:0]                       burst_idx;
    logic [31:0]                       beat_cnt;
    logic [31:0]                       start_beats;
    logic [31:0]                       rem_after;
    logic [C_S_AXI_DATA_WIDTH-1:0]     calc_host_addr;
    logic [31:0]                       calc_rem;
    logic [31:0]                       calc_idx;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     calc_awaddr;
    logic [7:0]                        calc_awlen;
    logic                              w_fire;

    assign M_AXI_AWSIZE  = axi_size(C_M_AXI_DATA_WIDTH / 8);
    assign M_AXI_AWBURST = BURST_INCR;

    // Data phase is a direct passthrough between the result stream and the W channel.
    assign M_AXI_WDATA  = s_res_data;
    assign M_AXI_WVALID = (state == ST_DATA) && s_res_valid;
    assign s_res_ready  = (state == ST_DATA) && M_AXI_WREADY;
    assign M_AXI_WLAST  = (state == ST_DATA) && (beat_cnt == 32'(M_AXI_AWLEN));
    assign w_fire       = M_AXI_WVALID && M_AXI_WREADY;

    assign start_beats = 32'(host_wr_len >> BEAT_SHIFT);
    assign rem_after   = remaining - 32'(M_AXI_AWLEN) - 32'd1;

    // The calculator sees the values the next burst will use, so AW is loaded in one edge.
    always_comb begin
        if (state == ST_IDLE) begin
            calc_host_addr = host_wr_addr;
            calc_rem       = start_beats;
            calc_idx       = '0;
        end else begin
            calc_host_addr = host_addr_q;
            calc_rem       = rem_after;
            calc_idx       = burst_idx + 32'd1;
        end
    end

    tfhe_wr_burst_calc #(
        .BASE_ADDR    (C_M_TARGET_SLAVE_BASE_ADDR),
        .BURST_LEN    (C_M_AXI_BURST_LEN),
        .ADDR_WIDTH   (C_M_AXI_ADDR_WIDTH),
        .DATA_WIDTH   (C_M_AXI_DATA_WIDTH),
        .S_DATA_WIDTH (C_S_AXI_DATA_WIDTH)
    ) u_burst_calc (
        .host_addr (calc_host_addr),
        .remaining (calc_rem),
        .burst_idx (calc_idx),
        .awaddr    (calc_awaddr),
        .awlen     (calc_awlen)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state         <= ST_IDLE;
            host_addr_q   <= '0;
            remaining     <= '0;
            burst_idx     <= '0;
            beat_cnt      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            wr_busy       <= 1'b0;
            wr_done       <= 1'b0;
            wr_error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_wr) begin
                        wr_error    <= 1'b0;
                        host_addr_q <= host_wr_addr;
                        remaining   <= start_beats;
                        burst_idx   <= '0;
                        if (start_beats == '0) begin
                            wr_done <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            wr_busy       <= 1'b1;
                            M_AXI_AWADDR  <= calc_awaddr;
                            M_AXI_AWLEN   <= calc_awlen;
                            M_AXI_AWVALID <= 1'b1;
                            state         <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (M_AXI_WLAST) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        remaining    <= rem_after;
                        if (M_AXI_BRESP != RESP_OKAY) wr_error <= 1'b1;
                        if (rem_after != '0) begin
                            burst_idx     <= burst_idx + 32'd1;
                            M_AXI_AWADDR  <= calc_awaddr;
                            M_AXI_AWLEN   <= calc_awlen;
                            M_AXI_AWVALID <= 1'b1;
                            state         <= ST_ADDR;
                        end else begin
                            wr_busy <= 1'b0;
                            wr_done <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    wr_done <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TFHE_WR_PERF_CNT_EN
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            wr_stall_cycles <= '0;
        end else if ((state == ST_IDLE) && start_wr) begin
            wr_stall_cycles <= '0;
        end else if ((state == ST_DATA) && !w_fire && (wr_stall_cycles != '1)) begin
            wr_stall_cycles <= wr_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tfhe_axi_burst_writer.sv
// Directed self-checking bench for tfhe_axi_burst_writer with a cycle-stepped AXI slave/stream model.
module tb_tfhe_axi_burst_writer;

    logic         clk = 1'b0;
    logic         M_AXI_ARESET;
    logic         start_wr;
    logic [31:0]  host_wr_addr;
    logic [31:0]  host_wr_len;
    logic [255:0] s_res_data;
    logic         s_res_valid;
    logic         s_res_ready;
    logic [63:0]  M_AXI_AWADDR;
    logic [7:0]   M_AXI_AWLEN;
    logic [2:0]   M_AXI_AWSIZE;
    logic [1:0]   M_AXI_AWBURST;
    logic         M_AXI_AWVALID;
    logic         M_AXI_AWREADY;
    logic [255:0] M_AXI_WDATA;
    logic         M_AXI_WLAST;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY;
    logic [1:0]   M_AXI_BRESP;
    logic         M_AXI_BVALID;
    logic         M_AXI_BREADY;
    logic         wr_busy;
    logic         wr_done;
    logic         wr_error;

    tfhe_axi_burst_writer #(
        .C_M_TARGET_SLAVE_BASE_ADDR (64'h40000000),
        .C_M_AXI_BURST_LEN          (16),
        .C_M_AXI_ADDR_WIDTH         (64),
        .C_M_AXI_DATA_WIDTH         (256),
        .C_S_AXI_DATA_WIDTH         (32)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (M_AXI_ARESET),
        .start_wr      (start_wr),
        .host_wr_addr  (host_wr_addr),
        .host_wr_len   (host_wr_len),
        .s_res_data    (s_res_data),
        .s_res_valid   (s_res_valid),
        .s_res_ready   (s_res_ready),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .wr_busy       (wr_busy),
        .wr_done       (wr_done),
        .wr_error      (wr_error)
    );

    initial forever #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Stimulus controls and slave model state.
    logic        rst = 1'b1;
    logic        start_req = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] start_len = '0;
    logic        rand_mode = 1'b0;
    int unsigned b_delay = 0;
    logic [1:0]  bresp_first = 2'b00;
    logic        b_pending = 1'b0;
    int unsigned b_wait = 0;
    int unsigned b_count = 0;
    int          bursts_open = 0;
    int unsigned overlap = 0;
    int unsigned src_idx = 0;
    int unsigned w_count = 0;
    int unsigned data_err = 0;
    int unsigned done_cnt = 0;
    logic        err_at_done = 1'b0;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int unsigned last_q[$];

    function automatic logic [255:0] word(input int unsigned i);
        logic [255:0] w;
        for (int unsigned l = 0; l < 8; l++) w[l*32 +: 32] = (32'(l) << 28) | 32'(i);
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_env();
        b_pending = 1'b0; b_wait = 0; b_count = 0; bursts_open = 0; overlap = 0;
        src_idx = 0; w_count = 0; data_err = 0; done_cnt = 0; err_at_done = 1'b0;
        aw_addr_q.delete(); aw_len_q.delete(); last_q.delete();
    endtask

    // One clock: drive inputs at negedge, then observe what the next posedge will accept.
    task automatic cycle();
        @(negedge clk);
        M_AXI_ARESET  = rst;
        start_wr      = start_req;
        host_wr_addr  = start_addr;
        host_wr_len   = start_len;
        start_req     = 1'b0;
        M_AXI_AWREADY = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        M_AXI_WREADY  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_res_valid   = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_res_data    = word(src_idx);
        if (b_pending && b_wait > 0) begin
            b_wait--;
            M_AXI_BVALID = 1'b0;
        end else begin
            M_AXI_BVALID = b_pending;
        end
        M_AXI_BRESP = (b_count == 0) ? bresp_first : 2'b00;
        #1;
        if (!rst) begin
            if (M_AXI_AWVALID && bursts_open > 0) overlap++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_addr_q.push_back(M_AXI_AWADDR);
                aw_len_q.push_back(M_AXI_AWLEN);
                bursts_open++;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                if (M_AXI_WDATA !== word(w_count)) data_err++;
                if (M_AXI_WLAST) begin
                    last_q.push_back(w_count);
                    b_pending = 1'b1;
                    b_wait    = b_delay;
                end
                w_count++;
            end
            if (s_res_valid && s_res_ready) src_idx++;
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_pending = 1'b0;
                b_count++;
                bursts_open--;
            end
            if (wr_done) begin
                done_cnt++;
                err_at_done = wr_error;
            end
        end
    endtask

    task automatic run_until_done(input int unsigned budget);
        for (int unsigned i = 0; i < budget && done_cnt == 0; i++) cycle();
    endtask

    task automatic expect_transfer(input string t, input int unsigned beats,
                                   input logic [63:0] a0, input logic [63:0] a1,
                                   input logic [7:0] l1, input logic err);
        check_eq({t, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_eq({t, "_aw_count"}, 64'(aw_addr_q.size()), 64'd2);
        check_eq({t, "_awaddr0"}, aw_addr_q[0], a0);
        check_eq({t, "_awaddr1"}, aw_addr_q[1], a1);
        check_eq({t, "_awlen0"}, 64'(aw_len_q[0]), 64'd15);
        check_eq({t, "_awlen1"}, 64'(aw_len_q[1]), 64'(l1));
        check_eq({t, "_beats"}, 64'(w_count), 64'(beats));
        check_eq({t, "_wlast_count"}, 64'(last_q.size()), 64'd2);
        check_eq({t, "_wlast0"}, 64'(last_q[0]), 64'd15);
        check_eq({t, "_wlast1"}, 64'(last_q[1]), 64'(beats - 1));
        check_eq({t, "_data_order"}, 64'(data_err), 64'd0);
        check_eq({t, "_aw_overlap"}, 64'(overlap), 64'd0);
        check_eq({t, "_err_at_done"}, 64'(err_at_done), 64'(err));
    endtask

    task automatic start(input logic [31:0] addr, input logic [31:0] len);
        reset_env();
        start_addr = addr;
        start_len  = len;
        start_req  = 1'b1;
        cycle();
    endtask

    initial begin
        M_AXI_ARESET = 1'b1; start_wr = 1'b0; host_wr_addr = '0; host_wr_len = '0;
        s_res_data = '0; s_res_valid = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
        repeat (3) cycle();
        check_eq("reset_ctrl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, s_res_ready,
                                    wr_busy, wr_done, wr_error}), 64'd0);
        check_eq("reset_awaddr", M_AXI_AWADDR, 64'd0);
        check_eq("reset_awlen", 64'(M_AXI_AWLEN), 64'd0);
        check_eq("awsize", 64'(M_AXI_AWSIZE), 64'd5);
        check_eq("awburst", 64'(M_AXI_AWBURST), 64'd1);
        rst = 1'b0;
        cycle();

        // 32 beats, two full bursts, slave always ready.
        start(32'h0, 32'h400);
        cycle();
        check_eq("t1_busy_after_start", 64'(wr_busy), 64'd1);
        check_eq("t1_awvalid_after_start", 64'(M_AXI_AWVALID), 64'd1);
        run_until_done(500);
        expect_transfer("t1", 32, 64'h40000000, 64'h40000200, 8'd15, 1'b0);
        cycle();
        check_eq("t1_idle_busy_done", 64'({wr_busy, wr_done}), 64'd0);

        // 19 beats: full burst then a 3-beat tail.
        start(32'h0, 32'h260);
        run_until_done(500);
        expect_transfer("t2", 19, 64'h40000000, 64'h40000200, 8'd2, 1'b0);
        cycle();

        // Zero length completes immediately with no address phase.
        start(32'h0, 32'h0);
        check_eq("zero_done_early", 64'(wr_done), 64'd0);
        cycle();
        check_eq("zero_done_pulse", 64'({wr_done, wr_busy}), 64'b10);
        cycle();
        check_eq("zero_done_clear", 64'(wr_done), 64'd0);
        check_eq("zero_no_aw", 64'(aw_addr_q.size()), 64'd0);

        // Random backpressure, slow B response, nonzero host offset.
        rand_mode = 1'b1;
        b_delay   = 20;
        start(32'h400, 32'h400);
        run_until_done(3000);
        expect_transfer("t3", 32, 64'h40000400, 64'h40000600, 8'd15, 1'b0);
        rand_mode = 1'b0;
        b_delay   = 2;
        cycle();

        // SLVERR on the first burst: second burst still written, error sticky until next start.
        bresp_first = 2'b10;
        start(32'h0, 32'h400);
        run_until_done(500);
        expect_transfer("t4", 32, 64'h40000000, 64'h40000200, 8'd15, 1'b1);
        bresp_first = 2'b00;
        repeat (2) cycle();
        check_eq("t4_error_sticky", 64'(wr_error), 64'd1);
        start(32'h0, 32'h0);
        cycle();
        check_eq("t4_error_cleared", 64'({wr_done, wr_error}), 64'b10);
        cycle();

        // Reset while beat 5 of the first burst is on the bus.
        b_delay = 0;
        start(32'h0, 32'h400);
        for (int unsigned i = 0; i < 100 && w_count < 4; i++) cycle();
        check_eq("t5_reached_beat5", 64'(w_count), 64'd4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check_eq("t5_outs_after_reset", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                             s_res_ready, wr_busy, wr_done}), 64'd0);
        reset_env();
        repeat (5) cycle();
        check_eq("t5_quiet_after_reset", 64'(aw_addr_q.size() + w_count), 64'd0);
        start(32'h0, 32'h260);
        run_until_done(500);
        expect_transfer("t5", 19, 64'h40000000, 64'h40000200, 8'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
